cpu_clk_step_ctrl: RTL

Clock-enable, reset-sequencing and debug-display controller that sits between the board clock/reset and the processor, RegFile, ROM and RAM. It replaces a fixed divide-by-2 clock with a single-domain clock enable. It adds:
- a programmable divide ratio
- single-step and halt modes with a debounced step button
- a stretched processor reset
- a retired-enable counter
- a selectable LED debug channel

---
 rtl/cpu_clk_step_ctrl.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/cpu_clk_step_ctrl.sv
// Purpose: processor clock-enable, stretched reset, single-step/halt control and LED debug mux.
// Latency: cpu_en/cpu_reset/led/en_count are registered (1 cycle); step press to cpu_en is DEBOUNCE_CYCLES+3.
// Backpressure: none; cpu_en is a free-running enable pulse with no ready handshake.
module cpu_clk_step_ctrl #(
  parameter int DIV_WIDTH       = 8,
  parameter int RESET_HOLD      = 16,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int NUM_CH          = 4,
  parameter int LED_WIDTH       = 16
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [DIV_WIDTH-1:0]      div_ratio,
  input  logic [1:0]                mode,
  input  logic                      step_btn,
  input  logic [NUM_CH*32-1:0]      ch_data,
  input  logic [$clog2(NUM_CH)-1:0] ch_sel,
  output logic                      cpu_en,
  output logic                      cpu_reset,
  output logic [LED_WIDTH-1:0]      led,
  output logic [31:0]               en_count
);

  localparam int SEL_W  = $clog2(NUM_CH);
  localparam int HOLD_W = $clog2(RESET_HOLD + 1);
  localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES + 1);

  // Last hold-counter value before the processor is released.
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD - 1);
  // Debounce count at which the next differing sample completes the run.
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] MODE_RUN  = 2'b00;
  localparam logic [1:0] MODE_STEP = 2'b01;

  // HOLD: processor held in reset with enable forced on; LIVE: mode decides cpu_en.
  typedef enum logic {
    ST_HOLD = 1'b0,
    ST_LIVE = 1'b1
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [HOLD_W-1:0]    hold_cnt;
  logic [HOLD_W-1:0]    hold_cnt_nxt;
  logic [DIV_WIDTH-1:0] div_cnt;
  logic [DIV_WIDTH-1:0] div_cnt_nxt;
  logic                 cpu_en_nxt;
  logic                 cpu_reset_nxt;
  logic [31:0]          en_count_nxt;

  logic                 sync_q1;
  logic                 sync_q2;
  logic [DEB_W-1:0]     deb_cnt;
  logic                 deb_lvl;
  logic                 deb_rise;

  logic [LED_WIDTH-1:0] led_nxt;

  // Channel bits above LED_WIDTH are never displayed; reduce them so they read as consumed.
  logic                 unused_ch_bits;
  assign unused_ch_bits = ^ch_data;

  // Two-flop synchronizer for the raw push-button.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= step_btn;
      sync_q2 <= sync_q1;
    end
  end

  // Debouncer: accept a new level after DEBOUNCE_CYCLES consecutive samples that differ
  // from the current level; any sample matching the level restarts the run. Runs in every
  // mode so the level is always current; deb_rise flags a completed 0->1 for one cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      deb_cnt  <= '0;
      deb_lvl  <= 1'b0;
      deb_rise <= 1'b0;
    end else begin
      deb_rise <= 1'b0;
      if (sync_q2 == deb_lvl) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_LAST) begin
        deb_cnt  <= '0;
        deb_lvl  <= sync_q2;
        deb_rise <= sync_q2;
      end else begin
        deb_cnt <= deb_cnt + 1'b1;
      end
    end
  end

  // Sequencing state, divider and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_HOLD;
      hold_cnt  <= '0;
      div_cnt   <= '0;
      cpu_en    <= 1'b0;
      cpu_reset <= 1'b1;
      en_count  <= '0;
    end else begin
      state     <= state_nxt;
      hold_cnt  <= hold_cnt_nxt;
      div_cnt   <= div_cnt_nxt;
      cpu_en    <= cpu_en_nxt;
      cpu_reset <= cpu_reset_nxt;
      en_count  <= en_count_nxt;
    end
  end

  // Next-state and next-output logic. The hold phase overrides mode entirely; outside
  // it the divider only advances in run mode and sits at zero otherwise, so re-entering
  // run always starts a fresh div_ratio+1 period. A debounced rise that lands while not
  // in step mode is simply not consumed and is lost.
  always_comb begin
    state_nxt     = state;
    hold_cnt_nxt  = hold_cnt;
    div_cnt_nxt   = '0;
    cpu_en_nxt    = 1'b0;
    cpu_reset_nxt = 1'b0;
    en_count_nxt  = en_count;

    if (state == ST_HOLD) begin
      cpu_reset_nxt = 1'b1;
      cpu_en_nxt    = 1'b1;
      if (hold_cnt == HOLD_LAST) begin
        state_nxt = ST_LIVE;
      end else begin
        hold_cnt_nxt = hold_cnt + 1'b1;
      end
    end else begin
      case (mode)
        MODE_RUN: begin
          // >= rather than == so a ratio lowered below the count wraps at once.
          if (div_cnt >= div_ratio) begin
            cpu_en_nxt  = 1'b1;
            div_cnt_nxt = '0;
          end else begin
            div_cnt_nxt = div_cnt + 1'b1;
          end
        end
        MODE_STEP: begin
          cpu_en_nxt = deb_rise;
        end
        default: begin
          cpu_en_nxt = 1'b0;
        end
      endcase
      if (cpu_en_nxt) begin
        en_count_nxt = en_count + 32'd1;
      end
    end
  end

  // LED channel select; selects beyond the populated channels show blank.
  always_comb begin
    led_nxt = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (ch_sel == SEL_W'(k)) begin
        led_nxt = ch_data[32*k +: LED_WIDTH];
      end
    end
  end

  // Register the LED value so the display changes one cycle after its inputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      led <= '0;
    end else begin
      led <= led_nxt;
    end
  end

endmodule
